// File: rtl/kan_layer_sequencer.sv
// kan_layer_sequencer: walks every (neuron, feature) pair of one KAN layer on a
// single shared MAC. It issues feature and weight read addresses, aligns the
// MAC enable/clear strobes to the memory read latency, and hands each finished
// neuron result to the consumer through a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   RUN   | issuing one read per cycle for the current neuron
//   DRAIN | READ_LAT cycles letting the last product reach the MAC
//   EMIT  | accumulator holds a finished neuron; wait for res_ready
//   FIN   | one-cycle done pulse, then back to IDLE
module kan_layer_sequencer #(
    parameter int IN_FEATURES  = 784,
    parameter int OUT_FEATURES = 64,
    parameter int READ_LAT     = 1,
    parameter int FA_W = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1,
    parameter int WA_W = (IN_FEATURES * OUT_FEATURES > 1) ? $clog2(IN_FEATURES * OUT_FEATURES) : 1,
    parameter int NI_W = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic [FA_W-1:0] feat_addr,
    output logic [WA_W-1:0] wgt_addr,
    output logic            rd_en,
    output logic            mac_en,
    output logic            mac_clr,
    output logic            res_valid,
    output logic [NI_W-1:0] res_idx,
    input  logic            res_ready,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, FIN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          drain_cnt;
    logic [READ_LAT-1:0] pipe_issue;
    logic [READ_LAT-1:0] pipe_first;
    logic                feat_last;
    logic                neur_last;

    // feat_addr doubles as the feature counter; it holds its final value
    // through DRAIN/EMIT and is rewound when the next neuron starts, so the
    // address outputs stay frozen outside RUN.
    assign feat_last = (feat_addr == FA_W'(IN_FEATURES - 1));
    // res_idx doubles as the neuron counter.
    assign neur_last = (res_idx == NI_W'(OUT_FEATURES - 1));

    assign mac_en  = pipe_issue[READ_LAT-1];
    assign mac_clr = pipe_first[READ_LAT-1] & pipe_issue[READ_LAT-1];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and Moore control outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        rd_en     = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                rd_en = 1'b1;
                if (feat_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 3'(READ_LAT - 1)) state_nxt = EMIT;
            end
            EMIT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = neur_last ? FIN : RUN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address, neuron and drain counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            feat_addr <= '0;
            wgt_addr  <= '0;
            res_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        feat_addr <= '0;
                        wgt_addr  <= '0;
                        res_idx   <= '0;
                    end
                end
                RUN: begin
                    drain_cnt <= '0;
                    if (!feat_last) begin
                        feat_addr <= feat_addr + FA_W'(1);
                        wgt_addr  <= wgt_addr + WA_W'(1);
                    end
                end
                DRAIN: drain_cnt <= drain_cnt + 3'd1;
                EMIT: begin
                    // Weight address continues across neurons; the increment
                    // skipped on the last RUN cycle is applied here.
                    if (res_ready && !neur_last) begin
                        res_idx   <= res_idx + NI_W'(1);
                        feat_addr <= '0;
                        wgt_addr  <= wgt_addr + WA_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-latency pipe carrying {issue, first-feature} to the MAC strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_issue <= '0;
            pipe_first <= '0;
        end else begin
            pipe_issue[0] <= rd_en;
            pipe_first[0] <= rd_en && (feat_addr == '0);
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_issue[i] <= pipe_issue[i-1];
                pipe_first[i] <= pipe_first[i-1];
            end
        end
    end

endmodule

// File: tb/tb_kan_layer_sequencer.sv
// Directed bench for kan_layer_sequencer using three configurations:
// A (IN=4, OUT=3, LAT=1), B (IN=4, OUT=2, LAT=3), C (IN=1, OUT=2, LAT=1).
module tb_kan_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic a_start, a_ready, a_busy, a_rd, a_mac, a_clr, a_valid, a_done;
    logic [1:0] a_feat;
    logic [3:0] a_wgt;
    logic [1:0] a_idx;

    logic b_start, b_ready, b_busy, b_rd, b_mac, b_clr, b_valid, b_done;
    logic [1:0] b_feat;
    logic [2:0] b_wgt;
    logic [0:0] b_idx;

    logic c_start, c_ready, c_busy, c_rd, c_mac, c_clr, c_valid, c_done;
    logic [0:0] c_feat;
    logic [0:0] c_wgt;
    logic [0:0] c_idx;

    int tests = 0;
    int fails = 0;

    kan_layer_sequencer #(.IN_FEATURES(4), .OUT_FEATURES(3), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy),
        .feat_addr(a_feat), .wgt_addr(a_wgt), .rd_en(a_rd), .mac_en(a_mac),
        .mac_clr(a_clr), .res_valid(a_valid), .res_idx(a_idx),
        .res_ready(a_ready), .done(a_done));

    kan_layer_sequencer #(.IN_FEATURES(4), .OUT_FEATURES(2), .READ_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy),
        .feat_addr(b_feat), .wgt_addr(b_wgt), .rd_en(b_rd), .mac_en(b_mac),
        .mac_clr(b_clr), .res_valid(b_valid), .res_idx(b_idx),
        .res_ready(b_ready), .done(b_done));

    kan_layer_sequencer #(.IN_FEATURES(1), .OUT_FEATURES(2), .READ_LAT(1)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .busy(c_busy),
        .feat_addr(c_feat), .wgt_addr(c_wgt), .rd_en(c_rd), .mac_en(c_mac),
        .mac_clr(c_clr), .res_valid(c_valid), .res_idx(c_idx),
        .res_ready(c_ready), .done(c_done));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        tick();
        tick();
        tests++;
        if ({a_busy, a_rd, a_mac, a_clr, a_valid, a_done, a_feat, a_wgt, a_idx} !== 14'd0) begin
            fails++;
            $display("FAIL reset_a outputs got=%b exp=0",
                     {a_busy, a_rd, a_mac, a_clr, a_valid, a_done, a_feat, a_wgt, a_idx});
        end
        tests++;
        if ({b_busy, b_rd, b_mac, b_clr, b_valid, b_done, b_feat, b_wgt, b_idx} !== 12'd0) begin
            fails++;
            $display("FAIL reset_b outputs got=%b exp=0",
                     {b_busy, b_rd, b_mac, b_clr, b_valid, b_done, b_feat, b_wgt, b_idx});
        end
        tests++;
        if ({c_busy, c_rd, c_mac, c_clr, c_valid, c_done, c_feat, c_wgt, c_idx} !== 9'd0) begin
            fails++;
            $display("FAIL reset_c outputs got=%b exp=0",
                     {c_busy, c_rd, c_mac, c_clr, c_valid, c_done, c_feat, c_wgt, c_idx});
        end
        reset = 1'b0;
        tick();
    endtask

    // IN=4 OUT=3 LAT=1: 6 cycles per neuron, done at cycle 19.
    task automatic test_nominal();
        logic [5:0] exp_ctl;
        logic [3:0] exp_wgt;
        int n, p;
        a_ready = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            n = 0; p = 0;
            if (c <= 18) begin
                n = (c - 1) / 6;
                p = (c - 1) % 6;
                // {busy, rd_en, mac_en, mac_clr, res_valid, done}
                exp_ctl = {1'b1, p < 4, p >= 1 && p <= 4, p == 1, p == 5, 1'b0};
            end else if (c == 19) begin
                exp_ctl = 6'b100001;
            end else begin
                exp_ctl = 6'b000000;
            end
            tests++;
            if ({a_busy, a_rd, a_mac, a_clr, a_valid, a_done} !== exp_ctl) begin
                fails++;
                $display("FAIL nominal_ctl c=%0d got=%b exp=%b", c,
                         {a_busy, a_rd, a_mac, a_clr, a_valid, a_done}, exp_ctl);
            end
            if (c <= 18 && p < 4) begin
                exp_wgt = 4'(n * 4 + p);
                tests++;
                if (a_feat !== 2'(p) || a_wgt !== exp_wgt) begin
                    fails++;
                    $display("FAIL nominal_addr c=%0d feat=%0d wgt=%0d exp_feat=%0d exp_wgt=%0d",
                             c, a_feat, a_wgt, p, exp_wgt);
                end
            end
            if (c <= 18 && p == 5) begin
                tests++;
                if (a_idx !== 2'(n)) begin
                    fails++;
                    $display("FAIL nominal_idx c=%0d got=%0d exp=%0d", c, a_idx, n);
                end
            end
            tick();
        end
    endtask

    // Second layer right after the first; start pulses in RUN and FIN ignored.
    task automatic test_back_to_back();
        a_ready = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) begin
                tests++;
                if (a_wgt !== 4'd0 || a_feat !== 2'd0 || a_rd !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_restart wgt=%0d feat=%0d rd=%b exp 0 0 1", a_wgt, a_feat, a_rd);
                end
            end
            tests++;
            if (a_done !== (c == 19) || a_busy !== (c <= 19)) begin
                fails++;
                $display("FAIL b2b_done c=%0d done=%b busy=%b exp done=%b busy=%b",
                         c, a_done, a_busy, c == 19, c <= 19);
            end
            a_start = (c == 3 || c == 19);
            tick();
        end
        a_start = 1'b0;
    endtask

    // Consumer stalls 5 cycles on the first result.
    task automatic test_stall();
        int dc;
        a_ready = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        for (int c = 6; c <= 10; c++) begin
            tests++;
            if ({a_valid, a_idx, a_rd, a_mac, a_feat, a_wgt} !== {1'b1, 2'd0, 1'b0, 1'b0, 2'd3, 4'd3}) begin
                fails++;
                $display("FAIL stall_hold c=%0d valid=%b idx=%0d rd=%b mac=%b feat=%0d wgt=%0d exp 1 0 0 0 3 3",
                         c, a_valid, a_idx, a_rd, a_mac, a_feat, a_wgt);
            end
            tick();
        end
        a_ready = 1'b1;
        tests++;
        if (a_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_valid11 got=%b exp=1", a_valid);
        end
        tick();
        tests++;
        if ({a_valid, a_rd, a_feat, a_wgt, a_idx} !== {1'b0, 1'b1, 2'd0, 4'd4, 2'd1}) begin
            fails++;
            $display("FAIL stall_resume valid=%b rd=%b feat=%0d wgt=%0d idx=%0d exp 0 1 0 4 1",
                     a_valid, a_rd, a_feat, a_wgt, a_idx);
        end
        dc = -1;
        for (int c = 12; c <= 40; c++) begin
            if (a_done) begin
                dc = c;
                break;
            end
            tick();
        end
        tests++;
        if (dc != 24) begin
            fails++;
            $display("FAIL stall_done_cycle got=%0d exp=24", dc);
        end
        tick();
        tests++;
        if (a_busy !== 1'b0) begin
            fails++;
            $display("FAIL stall_idle busy=%b exp=0", a_busy);
        end
    endtask

    // IN=4 OUT=2 LAT=3: 8 cycles per neuron, done at cycle 17.
    task automatic test_latency3();
        logic [5:0] exp_ctl;
        int n, p;
        b_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            n = 0; p = 0;
            if (c <= 16) begin
                n = (c - 1) / 8;
                p = (c - 1) % 8;
                exp_ctl = {1'b1, p < 4, p >= 3 && p <= 6, p == 3, p == 7, 1'b0};
            end else if (c == 17) begin
                exp_ctl = 6'b100001;
            end else begin
                exp_ctl = 6'b000000;
            end
            tests++;
            if ({b_busy, b_rd, b_mac, b_clr, b_valid, b_done} !== exp_ctl) begin
                fails++;
                $display("FAIL lat3_ctl c=%0d got=%b exp=%b", c,
                         {b_busy, b_rd, b_mac, b_clr, b_valid, b_done}, exp_ctl);
            end
            if (c <= 16 && p < 4) begin
                tests++;
                if (b_wgt !== 3'(n * 4 + p)) begin
                    fails++;
                    $display("FAIL lat3_wgt c=%0d got=%0d exp=%0d", c, b_wgt, n * 4 + p);
                end
            end
            if (c <= 16 && p == 7) begin
                tests++;
                if (b_idx !== 1'(n)) begin
                    fails++;
                    $display("FAIL lat3_idx c=%0d got=%0d exp=%0d", c, b_idx, n);
                end
            end
            tick();
        end
    endtask

    // Reset during neuron 1 aborts without done; next layer is clean.
    task automatic test_reset_mid();
        int dc;
        a_ready = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        tests++;
        if (a_rd !== 1'b1 || a_wgt !== 4'd5) begin
            fails++;
            $display("FAIL rstmid_pre rd=%b wgt=%0d exp 1 5", a_rd, a_wgt);
        end
        reset = 1'b1;
        tick();
        tests++;
        if ({a_busy, a_rd, a_mac, a_clr, a_valid, a_done, a_feat, a_wgt, a_idx} !== 14'd0) begin
            fails++;
            $display("FAIL rstmid_zero got=%b exp=0",
                     {a_busy, a_rd, a_mac, a_clr, a_valid, a_done, a_feat, a_wgt, a_idx});
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({a_busy, a_done, a_mac} !== 3'b000) begin
                fails++;
                $display("FAIL rstmid_quiet k=%0d busy/done/mac=%b exp=000", k, {a_busy, a_done, a_mac});
            end
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tests++;
        if (a_rd !== 1'b1 || a_wgt !== 4'd0 || a_feat !== 2'd0 || a_clr !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_restart rd=%b wgt=%0d feat=%0d clr=%b exp 1 0 0 0", a_rd, a_wgt, a_feat, a_clr);
        end
        dc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (a_done) begin
                dc = c;
                break;
            end
            tick();
        end
        tests++;
        if (dc != 19) begin
            fails++;
            $display("FAIL rstmid_done_cycle got=%0d exp=19", dc);
        end
        tick();
    endtask

    // IN=1 OUT=2: 3 cycles per neuron, mac_en and mac_clr coincide.
    task automatic test_single_feature();
        logic [5:0] exp_ctl;
        int n, p;
        c_ready = 1'b1;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n = 0; p = 0;
            if (c <= 6) begin
                n = (c - 1) / 3;
                p = (c - 1) % 3;
                exp_ctl = {1'b1, p == 0, p == 1, p == 1, p == 2, 1'b0};
            end else if (c == 7) begin
                exp_ctl = 6'b100001;
            end else begin
                exp_ctl = 6'b000000;
            end
            tests++;
            if ({c_busy, c_rd, c_mac, c_clr, c_valid, c_done} !== exp_ctl) begin
                fails++;
                $display("FAIL single_ctl c=%0d got=%b exp=%b", c,
                         {c_busy, c_rd, c_mac, c_clr, c_valid, c_done}, exp_ctl);
            end
            if (c <= 6 && p == 0) begin
                tests++;
                if (c_wgt !== 1'(n) || c_feat !== 1'b0) begin
                    fails++;
                    $display("FAIL single_addr c=%0d wgt=%0d feat=%0d exp wgt=%0d feat=0", c, c_wgt, c_feat, n);
                end
            end
            if (c <= 6 && p == 2) begin
                tests++;
                if (c_idx !== 1'(n)) begin
                    fails++;
                    $display("FAIL single_idx c=%0d got=%0d exp=%0d", c, c_idx, n);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        #1;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_stall();
        test_latency3();
        test_reset_mid();
        test_single_feature();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
